// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//   8N1 serial receiver with oversampled bit timing. A falling edge on the idle
//   line starts a frame; the start bit is re-checked at its midpoint to reject
//   glitches, data bits are sampled LSB first at their midpoints, and the stop
//   bit decides between a data_valid pulse and a frame_error pulse. After a
//   framing error the receiver waits for the line to return high before it
//   re-arms, so a held-low (break) line reports only one error.
//
// Parameters
//   CLK_FREQ    system clock frequency in Hz
//   BAUD_RATE   serial bit rate
//   OVERSAMPLE  sample ticks per bit (even, >= 4)
//   DATA_BITS   data bits per frame
//
// Ports
//   clk_100MHz   in   1          system clock, rising edge
//   reset        in   1          synchronous, active-high reset
//   rx           in   1          asynchronous serial line, idles high
//   data_out     out  DATA_BITS  last correctly framed byte, held until next
//   data_valid   out  1          one-cycle pulse when data_out updates
//   frame_error  out  1          one-cycle pulse when the stop bit is low
//   busy         out  1          high whenever a frame is in progress
// -----------------------------------------------------------------------------
module uart_receiver #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk_100MHz,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 frame_error,
   output logic                 busy
);

   localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [SW-1:0] S_HALF   = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST   = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } state_t;

   logic                 r_rx_meta;
   logic                 r_rx_s;
   state_t               r_state;
   logic [DW-1:0]        r_div_cnt;
   logic [SW-1:0]        r_s_cnt;
   logic [BW-1:0]        r_b_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_data_out;
   logic                 r_data_valid;
   logic                 r_frame_error;

   state_t w_state_next;
   logic   w_tick;
   logic   w_div_clr;
   logic   w_s_clr;
   logic   w_b_clr;
   logic   w_b_inc;
   logic   w_shift_en;
   logic   w_load;
   logic   w_ferr;

   assign w_tick = (r_div_cnt == DIV_LAST);

   // Next-state and control decode. Every sample point is a tick on which
   // s_cnt has reached the end of its window; s_cnt restarts there so the
   // following window measures a full bit from the previous sample point.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path can
      // leave it unassigned, which would otherwise infer a latch.
      w_state_next = r_state;
      w_div_clr    = 1'b0;
      w_s_clr      = 1'b0;
      w_b_clr      = 1'b0;
      w_b_inc      = 1'b0;
      w_shift_en   = 1'b0;
      w_load       = 1'b0;
      w_ferr       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!r_rx_s) begin
               // Restart the divider so ticks are phase-aligned to the edge.
               w_state_next = ST_START;
               w_div_clr    = 1'b1;
               w_s_clr      = 1'b1;
            end
         end
         ST_START: begin
            if (w_tick && (r_s_cnt == S_HALF)) begin
               w_s_clr = 1'b1;
               if (!r_rx_s) begin
                  w_state_next = ST_DATA;
                  w_b_clr      = 1'b1;
               end else begin
                  w_state_next = ST_IDLE;   // line back high: glitch
               end
            end
         end
         ST_DATA: begin
            if (w_tick && (r_s_cnt == S_LAST)) begin
               w_s_clr    = 1'b1;
               w_shift_en = 1'b1;
               if (r_b_cnt == B_LAST) begin
                  w_state_next = ST_STOP;
               end else begin
                  w_b_inc = 1'b1;
               end
            end
         end
         ST_STOP: begin
            if (w_tick && (r_s_cnt == S_LAST)) begin
               w_s_clr = 1'b1;
               if (r_rx_s) begin
                  w_load       = 1'b1;
                  w_state_next = ST_IDLE;
               end else begin
                  w_ferr       = 1'b1;
                  w_state_next = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            if (r_rx_s) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         // Synchronizer resets to the idle line level so reset release
         // cannot look like a start edge.
         r_rx_meta     <= 1'b1;
         r_rx_s        <= 1'b1;
         r_state       <= ST_IDLE;
         r_div_cnt     <= '0;
         r_s_cnt       <= '0;
         r_b_cnt       <= '0;
         r_shift       <= '0;
         r_data_out    <= '0;
         r_data_valid  <= 1'b0;
         r_frame_error <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here, so every register samples
         // the values from before this edge regardless of statement order.
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
         r_state   <= w_state_next;

         if (w_div_clr || w_tick) begin
            r_div_cnt <= '0;
         end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
         end

         if (w_s_clr) begin
            r_s_cnt <= '0;
         end else if (w_tick) begin
            r_s_cnt <= r_s_cnt + 1'b1;
         end

         if (w_b_clr) begin
            r_b_cnt <= '0;
         end else if (w_b_inc) begin
            r_b_cnt <= r_b_cnt + 1'b1;
         end

         // LSB arrives first, so after DATA_BITS shifts it sits in bit 0.
         if (w_shift_en) begin
            r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
         end

         if (w_load) begin
            r_data_out <= r_shift;
         end

         r_data_valid  <= w_load;
         r_frame_error <= w_ferr;
      end
   end

   assign data_out    = r_data_out;
   assign data_valid  = r_data_valid;
   assign frame_error = r_frame_error;
   assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
//   Drives serial frames into uart_receiver and compares every data_valid /
//   frame_error pulse against expectations built from the frame contents:
//   a frame with a high stop bit yields its byte, a low stop bit yields an
//   error with data_out unchanged. A small clock divider (DIV = 2) keeps
//   frames short; latency is 152*DIV + 3 cycles from the start edge.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

   localparam int CLK_FREQ = 100_000_000;
   localparam int BAUD     = 3_125_000;
   localparam int OS       = 16;
   localparam int DB       = 8;
   localparam int DIV      = CLK_FREQ / (BAUD * OS);     // 2
   localparam int BIT      = OS * DIV;                   // cycles per bit
   localparam int FRAME    = 10 * BIT;
   localparam int LAT      = (OS / 2 + (DB + 1) * OS) * DIV + 3;

   typedef struct {
      logic       err;
      logic [7:0] data;
      int         cyc;
   } ev_t;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_err;
      logic [7:0] exp_dout;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_error;
   logic       busy;

   int  cyc = 0;
   int  n_tests = 0;
   int  n_fail = 0;
   int  n_both = 0;
   int  n_long = 0;
   int  busy_run = 0;
   bit  prev_dv = 1'b0;
   bit  prev_fe = 1'b0;
   bit  prev_busy = 1'b0;
   bit  burst_on = 1'b0;
   ev_t ev_q[$];
   int  low_runs[$];

   uart_receiver #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD_RATE  (BAUD),
      .OVERSAMPLE (OS),
      .DATA_BITS  (DB)
   ) dut (
      .clk_100MHz  (clk),
      .reset       (reset),
      .rx          (rx),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .frame_error (frame_error),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse collector, sampled away from the active edge.
   always @(negedge clk) begin
      if (data_valid || frame_error) begin
         ev_q.push_back('{err: frame_error, data: data_out, cyc: cyc});
      end
      if (data_valid && frame_error) n_both <= n_both + 1;
      if ((data_valid && prev_dv) || (frame_error && prev_fe)) n_long <= n_long + 1;
      if (busy && !prev_busy && burst_on) low_runs.push_back(busy_run);
      busy_run  <= busy ? 0 : busy_run + 1;
      prev_dv   <= data_valid;
      prev_fe   <= frame_error;
      prev_busy <= busy;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_tests++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives the first nbits of {stop, data, start}; bit k ends at
   // round((k+1) * BIT * scale) cycles after the start edge.
   task automatic send_frame(input logic [7:0] d, input logic stop, input real scale,
                             input int nbits, output int t_start);
      logic [9:0] bits;
      int prev;
      int nxt;
      bits    = {stop, d, 1'b0};
      prev    = 0;
      t_start = cyc;
      for (int k = 0; k < nbits; k++) begin
         nxt = $rtoi(real'(k + 1) * real'(BIT) * scale + 0.5);
         rx  = bits[k];
         step(nxt - prev);
         prev = nxt;
      end
   endtask

   task automatic expect_frame(input string name, input int t_start, input logic exp_err,
                               input logic [7:0] exp_dout, input bit chk_lat);
      ev_t e;
      bit  got;
      got = 1'b0;
      for (int i = 0; i < 2 * FRAME && !got; i++) begin
         if (ev_q.size() > 0) got = 1'b1;
         else step(1);
      end
      if (!got) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: no pulse within %0d cycles", name, 2 * FRAME);
      end else begin
         e = ev_q.pop_front();
         check({name, "_err"}, 32'(e.err), 32'(exp_err));
         check({name, "_data"}, 32'(e.data), 32'(exp_dout));
         if (chk_lat) check_range({name, "_latency"}, e.cyc - t_start, LAT - 2, LAT + 2);
      end
   endtask

   initial begin
      vec_t vecs[8];
      int   t;
      int   t0;
      int   bcnt;
      int   bad;
      ev_t  e;
      ev_t  prev_e;
      logic [7:0] model_last;
      logic       exp_err_q[$];
      logic [7:0] exp_dout_q[$];

      vecs[0] = '{8'h41, 1'b1, 1'b0, 8'h41};
      vecs[1] = '{8'h00, 1'b1, 1'b0, 8'h00};
      vecs[2] = '{8'hFF, 1'b1, 1'b0, 8'hFF};
      vecs[3] = '{8'h7E, 1'b0, 1'b1, 8'hFF};
      vecs[4] = '{8'h80, 1'b1, 1'b0, 8'h80};
      vecs[5] = '{8'h01, 1'b1, 1'b0, 8'h01};
      vecs[6] = '{8'hA5, 1'b0, 1'b1, 8'h01};
      vecs[7] = '{8'h5A, 1'b1, 1'b0, 8'h5A};

      // Reset state.
      rx    = 1'b1;
      reset = 1'b1;
      step(4);
      @(negedge clk);
      check("rst_data_out", 32'(data_out), 32'h00);
      check("rst_data_valid", 32'(data_valid), 32'h0);
      check("rst_frame_error", 32'(frame_error), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(8);

      // Directed table: good frames, bad stop bits, latency.
      for (int i = 0; i < 8; i++) begin
         send_frame(vecs[i].data, vecs[i].stop, 1.0, 10, t);
         rx = 1'b1;
         expect_frame($sformatf("vec%0d", i), t, vecs[i].exp_err, vecs[i].exp_dout, 1'b1);
         step(BIT);
      end

      // Start-bit glitch of 3 ticks: busy for exactly 8 ticks, no pulse.
      bcnt = 0;
      rx   = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (busy) bcnt++;
         @(posedge clk);
         #1;
         if (i == 5) rx = 1'b1;
      end
      check("glitch_busy_cycles", 32'(bcnt), 32'(8 * DIV));
      check("glitch_no_pulse", 32'(ev_q.size()), 32'd0);
      check("glitch_idle", 32'(busy), 32'h0);
      send_frame(8'h55, 1'b1, 1.0, 10, t);
      expect_frame("after_glitch", t, 1'b0, 8'h55, 1'b1);
      step(BIT);

      // Framing error followed by a 20-bit break: exactly one error.
      send_frame(8'h7E, 1'b0, 1.0, 10, t);
      step(20 * BIT);
      check("break_pulse_count", 32'(ev_q.size()), 32'd1);
      expect_frame("break", t, 1'b1, 8'h55, 1'b1);
      rx = 1'b1;
      step(BIT);
      send_frame(8'h31, 1'b1, 1.0, 10, t);
      expect_frame("after_break", t, 1'b0, 8'h31, 1'b1);
      step(BIT);

      // Reset during data bit 4 of 0xA5; the partial frame is abandoned.
      send_frame(8'hA5, 1'b1, 1.0, 5, t);
      rx = 1'b0;                   // data bit 4 of 0xA5
      step(BIT / 2);
      reset = 1'b1;
      step(1);
      check("midrst_data_out", 32'(data_out), 32'h00);
      check("midrst_data_valid", 32'(data_valid), 32'h0);
      check("midrst_frame_error", 32'(frame_error), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      reset = 1'b0;
      rx    = 1'b1;
      step(2 * FRAME);
      check("midrst_no_pulse", 32'(ev_q.size()), 32'd0);
      send_frame(8'hA5, 1'b1, 1.0, 10, t);
      expect_frame("after_midrst", t, 1'b0, 8'hA5, 1'b1);
      step(BIT);

      // Baud skew of +3% and -3%.
      send_frame(8'hC3, 1'b1, 1.0 / 1.03, 10, t);
      expect_frame("skew_fast", t, 1'b0, 8'hC3, 1'b0);
      step(BIT);
      send_frame(8'hC3, 1'b1, 1.0 / 0.97, 10, t);
      expect_frame("skew_slow", t, 1'b0, 8'hC3, 1'b0);
      step(BIT);

      // 64 back-to-back frames 0x00..0x3F.
      low_runs.delete();
      burst_on = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 64; i++) begin
         send_frame(8'(i), 1'b1, 1.0, 10, t);
      end
      step(BIT);
      burst_on = 1'b0;
      check("burst_count", 32'(ev_q.size()), 32'd64);
      if (ev_q.size() == 64) begin
         bad = 0;
         for (int i = 0; i < 64; i++) begin
            e = ev_q.pop_front();
            check($sformatf("burst%0d_data", i), 32'(e.data), 32'(i));
            check($sformatf("burst%0d_err", i), 32'(e.err), 32'h0);
            if (i == 0) check_range("burst_latency", e.cyc - t0, LAT - 2, LAT + 2);
            else if (e.cyc - prev_e.cyc != FRAME) bad++;
            prev_e = e;
         end
         check("burst_spacing_errors", 32'(bad), 32'd0);
      end
      ev_q.delete();
      // Between frames the line is idle only from the stop-bit sample to the
      // next start entry: (10*BIT + 3) - LAT cycles.
      check("burst_runs", 32'(low_runs.size()), 32'd64);
      bad = 0;
      for (int i = 1; i < low_runs.size(); i++) begin
         if (low_runs[i] != 10 * BIT + 3 - LAT) bad++;
      end
      check("burst_idle_gaps", 32'(bad), 32'd0);

      // Randomized frames against the frame-level model.
      model_last = 8'h3F;
      for (int i = 0; i < 24; i++) begin
         logic [7:0] d;
         logic       s;
         real        sc;
         d  = 8'($urandom_range(0, 255));
         s  = ($urandom_range(0, 4) != 0);
         sc = 1.0 + real'(int'($urandom_range(0, 40)) - 20) / 1000.0;
         if (s) begin
            model_last = d;
            exp_err_q.push_back(1'b0);
         end else begin
            exp_err_q.push_back(1'b1);
         end
         exp_dout_q.push_back(model_last);
         send_frame(d, s, sc, 10, t);
         rx = 1'b1;
         step(s ? $urandom_range(0, BIT) : $urandom_range(4, BIT));
      end
      step(2 * FRAME);
      check("rand_count", 32'(ev_q.size()), 32'(exp_err_q.size()));
      for (int i = 0; i < 24 && ev_q.size() > 0; i++) begin
         e = ev_q.pop_front();
         check($sformatf("rand%0d_err", i), 32'(e.err), 32'(exp_err_q[i]));
         check($sformatf("rand%0d_data", i), 32'(e.data), 32'(exp_dout_q[i]));
      end

      check("pulse_overlap", 32'(n_both), 32'd0);
      check("pulse_width", 32'(n_long), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
